uart_msg_tx: RTL and testbench

UART_MSG_TX -- requirements
Module: uart_msg_tx

---
 rtl/uart_msg_tx.sv | 159 +++++++++++++++
 tb/tb_uart_msg_tx.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_msg_tx.sv
// rtl/uart_msg_tx.sv - message FIFO feeding an 8N1 UART serializer, whole messages sent byte 0 first
module uart_msg_tx #(
  parameter int MSG_BYTES    = 9,
  parameter int CLKS_PER_BIT = 1736,
  parameter int FIFO_DEPTH   = 2
) (
  input  logic                   clk,
  input  logic                   n_reset,
  input  logic [MSG_BYTES*8-1:0] uart_out_msg,
  input  logic                   uart_out_req,
  output logic                   uart_out_ready,
  output logic                   tx,
  output logic                   busy,
  output logic                   overflow
);

  localparam int MW = MSG_BYTES * 8;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PTR_LAST  = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [IW-1:0] IDX_LAST  = IW'(MSG_BYTES - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [MW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic          push, pop;

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [MW-1:0] shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          tick, has_msg, line;

  // Ready depends only on the registered count; a strobe while full is dropped.
  assign uart_out_ready = (count_q < DEPTH_C);
  assign push           = uart_out_req & uart_out_ready;
  assign has_msg        = (count_q != '0);
  assign tick           = (baud_q == BAUD_LAST);

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= uart_out_msg;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = uart_out_req & ~uart_out_ready;
    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Serializer; a queued message is popped straight from the last STOP so frames abut.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    line    = 1'b1;
    if (state_q != S_IDLE) baud_d = tick ? '0 : baud_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (has_msg) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          idx_d   = '0;
          bit_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        line = 1'b0;
        if (tick) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        line = shift_q[0];
        if (tick) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (idx_q != IDX_LAST) begin
            idx_d   = idx_q + 1'b1;
            state_d = S_START;
          end else if (has_msg) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            idx_d   = '0;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    tx_d   = line;
    busy_d = (state_q != S_IDLE) || has_msg;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= S_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_msg_tx.sv
// tb/tb_uart_msg_tx.sv - randomized bench for uart_msg_tx with a queue/timing reference model and 8N1 receiver
module tb_uart_msg_tx;
  localparam int MSG_BYTES = 9;
  localparam int CPB       = 4;
  localparam int DEPTH     = 2;
  localparam int MW        = MSG_BYTES * 8;
  localparam int BYTE_CYC  = 10 * CPB;
  localparam int FRAME     = MSG_BYTES * BYTE_CYC;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic          req = 1'b0;
  logic [MW-1:0] msg = '0;
  logic          ready, tx, busy, overflow;

  uart_msg_tx #(.MSG_BYTES(MSG_BYTES), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .n_reset(n_reset), .uart_out_msg(msg), .uart_out_req(req),
    .uart_out_ready(ready), .tx(tx), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [MW-1:0] mq[$];
  logic [MW-1:0] cur = '0;
  int            s_cyc = 0;
  bit            fv = 1'b0;
  logic [7:0]    rx_exp[$];
  logic [7:0]    rx_log[$];
  logic          e_tx = 1'b1, e_busy = 1'b0, e_ready = 1'b1, e_ovf = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line level of the current frame at cycle c: start, 8 data bits LSB first, stop; byte k = msg[8k+7:8k].
  function automatic logic exp_line(input int c);
    int p, b, r;
    if (!fv || c < s_cyc || c >= s_cyc + FRAME) return 1'b1;
    p = c - s_cyc;
    b = p / BYTE_CYC;
    r = (p % BYTE_CYC) / CPB;
    if (r == 0) return 1'b0;
    if (r == 9) return 1'b1;
    return cur[b*8 + r - 1];
  endfunction

  function automatic logic [MW-1:0] rand_msg();
    logic [MW-1:0] m;
    for (int i = 0; i < MSG_BYTES; i++) m[i*8 +: 8] = 8'($urandom);
    return m;
  endfunction

  initial begin : model
    int   qpre;
    bit   do_pop;
    bit   rx_act;
    int   rx_cnt;
    int   bi;
    logic [7:0] rx_byte;
    rx_act  = 1'b0;
    rx_cnt  = 0;
    rx_byte = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!n_reset) begin
        mq.delete();
        rx_exp.delete();
        fv      = 1'b0;
        e_tx    = 1'b1;
        e_busy  = 1'b0;
        e_ready = 1'b1;
        e_ovf   = 1'b0;
      end else begin
        qpre   = mq.size();
        do_pop = (qpre != 0) && (!fv || cyc >= s_cyc + FRAME - 1);
        e_ovf  = req && (qpre >= DEPTH);
        if (do_pop) begin
          cur   = mq.pop_front();
          s_cyc = cyc + 1;
          fv    = 1'b1;
        end
        if (req && qpre < DEPTH) begin
          mq.push_back(msg);
          for (int i = 0; i < MSG_BYTES; i++) rx_exp.push_back(msg[i*8 +: 8]);
        end
        e_tx    = exp_line(cyc);
        e_busy  = (fv && cyc >= s_cyc && cyc < s_cyc + FRAME) || (qpre != 0);
        e_ready = (mq.size() < DEPTH);
      end
      #1;
      check("tx", 64'(tx), 64'(e_tx));
      check("busy", 64'(busy), 64'(e_busy));
      check("ready", 64'(ready), 64'(e_ready));
      check("overflow", 64'(overflow), 64'(e_ovf));
      // Independent 8N1 receiver sampling each bit at its mid-point.
      if (!n_reset) begin
        rx_act = 1'b0;
      end else if (!rx_act) begin
        if (tx === 1'b0) begin
          rx_act  = 1'b1;
          rx_cnt  = 0;
          rx_byte = '0;
        end
      end else begin
        rx_cnt++;
      end
      if (rx_act && n_reset) begin
        if (rx_cnt == CPB/2) begin
          check("rx_start_mid", 64'(tx), 64'(0));
        end else if (rx_cnt == CPB/2 + 9*CPB) begin
          check("rx_stop_high", 64'(tx), 64'(1));
          rx_log.push_back(rx_byte);
          check("rx_byte_expected", 64'(rx_exp.size() != 0), 64'(1));
          if (rx_exp.size() != 0) check("rx_byte", 64'(rx_byte), 64'(rx_exp.pop_front()));
          rx_act = 1'b0;
        end else if (rx_cnt > CPB/2 && (rx_cnt - CPB/2) % CPB == 0) begin
          bi = (rx_cnt - CPB/2) / CPB - 1;
          rx_byte[bi] = tx;
        end
      end
    end
  end

  task automatic wait_start(output int lat);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      if (tx === 1'b0) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int bound, input string name);
    int k;
    k = 0;
    repeat (2) @(posedge clk);
    #1;
    while (busy !== 1'b0 && k < bound) begin
      @(posedge clk);
      #1;
      k++;
    end
    check(name, 64'(k < bound), 64'(1));
  endtask

  initial begin : stim
    int            lat, m;
    logic [MW-1:0] me;
    logic [7:0]    lit [MSG_BYTES];
    lit = '{8'hAA, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};

    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", 64'(tx), 64'(1));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_ready", 64'(ready), 64'(1));
    check("reset_overflow", 64'(overflow), 64'(0));
    @(negedge clk);
    n_reset = 1'b1;
    repeat (3) @(negedge clk);

    // Single known message: latency, duration, byte order.
    rx_log.delete();
    req = 1'b1;
    msg = 72'h8877665544332211AA;
    @(negedge clk);
    req = 1'b0;
    wait_start(lat);
    check("latency_edges", 64'(lat), 64'(2));
    m = 0;
    while (busy === 1'b1 && m < 5000) begin
      @(posedge clk);
      #1;
      m++;
    end
    check("frame_cycles", 64'(m), 64'(FRAME));
    check("rx_count_single", 64'(rx_log.size()), 64'(MSG_BYTES));
    if (rx_log.size() == MSG_BYTES)
      for (int i = 0; i < MSG_BYTES; i++) check("rx_single_byte", 64'(rx_log[i]), 64'(lit[i]));
    repeat (5) @(negedge clk);

    // Four strobes on consecutive cycles: three accepted, fourth overflows.
    req = 1'b1;
    msg = rand_msg();
    @(negedge clk);
    msg = rand_msg();
    @(negedge clk);
    msg = rand_msg();
    @(posedge clk);
    #1;
    check("ready_low_when_full", 64'(ready), 64'(0));
    check("burst_first_start", 64'(tx), 64'(0));
    @(negedge clk);
    msg = rand_msg();
    @(posedge clk);
    #1;
    m = 1;
    check("overflow_pulse", 64'(overflow), 64'(1));
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #1;
    m = 2;
    check("overflow_single_cycle", 64'(overflow), 64'(0));
    while (busy === 1'b1 && m < 5000) begin
      @(posedge clk);
      #1;
      m++;
    end
    check("burst_cycles", 64'(m), 64'(3 * FRAME));
    repeat (3) @(negedge clk);

    // Push on the very edge where the last STOP ends and the queued message pops.
    req = 1'b1;
    msg = rand_msg();
    @(negedge clk);
    req = 1'b0;
    wait_start(lat);
    check("latency_edges_2", 64'(lat), 64'(2));
    @(negedge clk);
    req = 1'b1;
    msg = rand_msg();
    @(negedge clk);
    req = 1'b0;
    repeat (FRAME - 3) @(posedge clk);
    @(negedge clk);
    req = 1'b1;
    msg = rand_msg();
    @(posedge clk);
    #1;
    check("ready_after_push_pop", 64'(ready), 64'(1));
    check("last_stop_high", 64'(tx), 64'(1));
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #1;
    check("next_start_no_gap", 64'(tx), 64'(0));
    wait_idle(5000, "push_pop_drain");

    // Reset during DATA of byte 4, then capture on the first edge after release.
    @(negedge clk);
    req = 1'b1;
    msg = rand_msg();
    @(negedge clk);
    req = 1'b0;
    wait_start(lat);
    repeat (4 * BYTE_CYC + 10) @(posedge clk);
    #3;
    n_reset = 1'b0;
    #1;
    check("async_reset_tx", 64'(tx), 64'(1));
    check("async_reset_busy", 64'(busy), 64'(0));
    check("async_reset_ready", 64'(ready), 64'(1));
    check("async_reset_overflow", 64'(overflow), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rx_log.delete();
    me      = rand_msg();
    n_reset = 1'b1;
    req     = 1'b1;
    msg     = me;
    @(negedge clk);
    req = 1'b0;
    wait_idle(5000, "post_reset_drain");
    check("rx_count_post_reset", 64'(rx_log.size()), 64'(MSG_BYTES));
    if (rx_log.size() == MSG_BYTES)
      for (int i = 0; i < MSG_BYTES; i++) check("rx_post_reset_byte", 64'(rx_log[i]), 64'(me[i*8 +: 8]));

    // Random bursts and gaps.
    for (int it = 0; it < 25; it++) begin
      int gap, burst;
      gap   = $urandom_range(0, 450);
      burst = $urandom_range(1, 3);
      repeat (gap) @(negedge clk);
      for (int j = 0; j < burst; j++) begin
        @(negedge clk);
        req = 1'b1;
        msg = rand_msg();
      end
      @(negedge clk);
      req = 1'b0;
    end
    wait_idle(20000, "final_drain");
    repeat (3) @(posedge clk);
    #1;
    check("all_bytes_received", 64'(rx_exp.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: run exceeded its cycle budget at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
